// File: rtl/debouncer_multi_if.sv
// Signal bundle between a debouncer_multi instance and its user: raw inputs in,
// debounced levels, edge events and the sampling strobe out.
interface debouncer_multi_if #(
  parameter int unsigned width = 1
);
  logic [width-1:0] glitchy_signal;
  logic [width-1:0] debounced_signal;
  logic [width-1:0] rise_pulse;
  logic [width-1:0] fall_pulse;
  logic             sample_tick;

  modport master (
    output glitchy_signal,
    input  debounced_signal,
    input  rise_pulse,
    input  fall_pulse,
    input  sample_tick
  );

  modport slave (
    input  glitchy_signal,
    output debounced_signal,
    output rise_pulse,
    output fall_pulse,
    output sample_tick
  );
endinterface

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: one shared sampling strobe, a saturating counter per channel,
// press-only or symmetric-hysteresis filtering, and registered one-cycle edge events.
module debouncer_multi #(
  parameter int unsigned width                  = 1,
  parameter int unsigned sampling_pulse_period  = 25000,
  parameter int unsigned saturating_counter_max = 150,
  parameter int unsigned hysteresis             = 0
) (
  input logic              clk,
  input logic              rst,
  debouncer_multi_if.slave bus
);

  localparam int unsigned SampleW = $clog2(sampling_pulse_period);
  localparam int unsigned CntW    = $clog2(saturating_counter_max + 1);

  localparam logic [SampleW-1:0] SampleLast = SampleW'(sampling_pulse_period - 1);
  localparam logic [CntW-1:0]    CntMax     = CntW'(saturating_counter_max);
  localparam bit                 UseHyst    = (hysteresis != 0);

  // Shared sampling counter; the tick is decoded combinationally from its last value.
  logic [SampleW-1:0] sample_cnt_q, sample_cnt_d;
  logic               tick;

  assign tick = (sample_cnt_q == SampleLast);

  always_comb begin
    sample_cnt_d = sample_cnt_q + 1'b1;
    if (tick) begin
      sample_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign bus.sample_tick = tick;

  for (genvar i = 0; i < width; i++) begin : g_chan
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            deb_q, deb_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            sample;

    assign sample = bus.glitchy_signal[i];

    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (tick) begin
        if (sample) begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end else if (UseHyst) begin
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end else begin
          cnt_d = '0;
        end
        // Press-only tracks "at max" directly; hysteresis holds the level between the ends.
        if (cnt_d == CntMax) begin
          deb_d = 1'b1;
        end else if (!UseHyst || (cnt_d == '0)) begin
          deb_d = 1'b0;
        end
      end
    end

    always_comb begin
      rise_d = deb_d & ~deb_q;
      fall_d = ~deb_d & deb_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        deb_q  <= deb_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign bus.debounced_signal[i] = deb_q;
    assign bus.rise_pulse[i]       = rise_q;
    assign bus.fall_pulse[i]       = fall_q;
  end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Multi-channel debouncer for synchronized push-button and switch inputs.
- Shared sampling-pulse generator; per-channel saturating counter.
- Two modes: press-only (counter cleared on any low sample) and symmetric hysteresis (debounces both press and release).
- Also emits one-cycle rise/fall event pulses for downstream FSMs (button-press consumers), so no separate edge detector is needed.

Parameters:
- width, 1, number of independent channels.
- sampling_pulse_period, 25000, clock cycles between sample ticks; must be >= 2.
- saturating_counter_max, 150, samples required to change debounced state; must be >= 1.
- hysteresis, 0, 0 = press-only mode; 1 = up/down hysteresis mode.
- Derived internally, not overridable: sampling counter width = ceil(log2(sampling_pulse_period)); saturating counter width = ceil(log2(saturating_counter_max+1)).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- glitchy_signal  input  width  already-synchronized, possibly bouncing inputs.
- debounced_signal  output  width  registered debounced level per channel.
- rise_pulse  output  width  one-cycle pulse when the channel's debounced level goes 0->1.
- fall_pulse  output  width  one-cycle pulse when the channel's debounced level goes 1->0.
- sample_tick  output  1  one-cycle sampling strobe, for debug and bench alignment.

Behaviour:
- Reset (rst=0, asynchronous): sampling counter=0; all channel counters=0; debounced_signal, rise_pulse, fall_pulse, sample_tick all 0 immediately, with no clock required.
  - Reset mid-count discards all progress.
  - After release, the first tick comes sampling_pulse_period cycles later.
- Sampling counter:
  - Counts 0..sampling_pulse_period-1, then wraps to 0.
  - sample_tick is combinational: high exactly while count == sampling_pulse_period-1.
  - Channel state updates only on the clock edge that ends a tick cycle.
- Press-only mode (hysteresis=0), per channel i, at each tick:
  - glitchy_signal[i]=1: cnt = min(cnt+1, max).
  - glitchy_signal[i]=0: cnt = 0.
  - debounced[i] is 1 iff cnt == max.
  - Any single low sample clears debounced[i] at that tick; no release filtering.
- Hysteresis mode (hysteresis=1), per channel i, at each tick:
  - glitchy_signal[i]=1: cnt = min(cnt+1, max).
  - glitchy_signal[i]=0: cnt = max(cnt-1, 0).
  - debounced[i] sets when the new cnt == max and clears when the new cnt == 0; otherwise it holds.
- Counter arithmetic saturates at both ends. Counters never wrap; no overflow is possible at the derived widths.
- Latency:
  - debounced[i] changes on the same edge the counter reaches its threshold.
  - Press-only, input steady high from reset release: the 0->1 change occurs on the edge ending cycle max*sampling_pulse_period-1 (cycles counted from 0 after release).
- Event pulses:
  - rise_pulse[i] and fall_pulse[i] are registered and asserted on the same edge debounced[i] changes.
  - They clear on the next edge, so they are exactly one cycle wide.
  - Both are never high together; ticks are at least 2 cycles apart.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- Input changes between ticks are ignored; only the value at the tick cycle is sampled.

Test Plan:
- Params width=1, period=4, max=3, hysteresis=0; release reset, hold input=1 -> sample_tick at cycles 3,7,11; debounced rises on edge ending cycle 11; rise_pulse high only during cycle 12.
- Same params; input=1 for 2 ticks, 0 at the 3rd tick, then 1 -> no debounced assertion until 3 further consecutive high ticks; no rise_pulse in between.
- hysteresis=1, max=3; saturate high, then sample pattern 0,1,0,0,0 -> cnt 2,3,2,1,0; debounced stays 1 until the final tick, then fall_pulse for one cycle.
- width=4; channels 0 and 2 driven high, 1 and 3 bouncing at half the tick rate -> only bits 0 and 2 rise, simultaneously; bits 1 and 3 stay 0.
- Assert rst=0 asynchronously mid-cycle while debounced=1 -> all outputs 0 before the next clk edge; after release with input held 1, assertion needs the full 3 ticks again.
- Input toggles every cycle except at tick cycles, where it is 1 -> treated as steady high; debounced asserts after 3 ticks.
